// File: rtl/rf_pkt_receiver.sv
// rf_pkt_receiver
//   Recovers packets from an RF detector output. Short pulses on din are
//   stretched across a bit period of DIV clocks. Each bit period yields one
//   sample, which is shifted into a sync hunter. Once SYNC_WORD is seen, the
//   next PKT_W samples are assembled into a payload. The payload is pushed
//   into a small first-word-fall-through FIFO that the readout side drains.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous reset, active low
//   din        in   RF detector output (pulses may last a single clock)
//   pkt_rd     in   pop the FIFO head (ignored while empty)
//   ovf_clr    in   clear the sticky overflow flag
//   pkt_data   out  FIFO head payload, first received bit in the MSB, 0 when empty
//   pkt_valid  out  FIFO holds at least one packet
//   pkt_rec    out  one-cycle strobe after a packet is written into the FIFO
//   fifo_count out  number of stored packets
//   overflow   out  sticky: a completed packet was dropped because the FIFO was full
//   hunting    out  high while searching for the sync word

module rf_pkt_receiver #(
    parameter int                PKT_W      = 64,
    parameter int                DIV        = 1000,
    parameter int                SYNC_W     = 8,
    parameter logic [SYNC_W-1:0] SYNC_WORD  = 8'hA5,
    parameter int                FIFO_DEPTH = 4,
    parameter int                CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             pkt_rd,
    input  logic             ovf_clr,
    output logic [PKT_W-1:0] pkt_data,
    output logic             pkt_valid,
    output logic             pkt_rec,
    output logic [CW-1:0]    fifo_count,
    output logic             overflow,
    output logic             hunting
);

    localparam int DW = $clog2(DIV);
    localparam int BW = $clog2(PKT_W);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {
        HUNT,
        RECV
    } state_t;

    state_t state, state_next;

    logic [DW-1:0]     div_cnt;
    logic              flag;
    logic              tick;
    logic              bit_s;
    logic [SYNC_W-1:0] sync_sh;
    logic [SYNC_W-1:0] sync_next;
    logic [PKT_W-1:0]  payload;
    logic [PKT_W-1:0]  payload_next;
    logic [BW-1:0]     bit_cnt;
    logic              sync_match;
    logic              last_bit;

    logic [PKT_W-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     rd_next;
    logic [CW-1:0]     count_next;
    logic [PKT_W-1:0]  head_next;
    logic              fifo_full;
    logic              pop;
    logic              push_ok;
    logic              drop;

    assign tick  = (div_cnt == DW'(DIV - 1));
    // A pulse counts if it was caught earlier in the window or is present on the tick itself.
    assign bit_s = flag | din;

    assign sync_next    = (sync_sh << 1) | SYNC_W'(bit_s);
    assign payload_next = (payload << 1) | PKT_W'(bit_s);

    assign sync_match = (state == HUNT) && tick && (sync_next == SYNC_WORD);
    assign last_bit   = (state == RECV) && tick && (bit_cnt == BW'(PKT_W - 1));

    assign fifo_full = (fifo_count == CW'(FIFO_DEPTH));
    assign pop       = pkt_rd && (fifo_count != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push_ok   = last_bit && (!fifo_full || pop);
    assign drop      = last_bit && !push_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= HUNT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            HUNT: if (sync_match) state_next = RECV;
            RECV: if (last_bit)   state_next = HUNT;
            default: state_next = HUNT;
        endcase
    end

    always_comb begin
        hunting = (state == HUNT);
    end

    // Bit timing, pulse stretching and the sync/payload shifters.
    // The flag is cleared on the tick rather than loaded with din, so a pulse
    // that straddles the tick only counts again if din is still high afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            flag    <= 1'b0;
            sync_sh <= '0;
            payload <= '0;
            bit_cnt <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DW'(1);
            flag    <= tick ? 1'b0 : (flag | din);
            if (tick) begin
                if (state == HUNT) begin
                    sync_sh <= sync_next;
                    if (sync_match) begin
                        bit_cnt <= '0;
                        payload <= '0;
                    end
                end else begin
                    payload <= payload_next;
                    bit_cnt <= bit_cnt + BW'(1);
                    // Payload bits must never contribute to the next sync match.
                    if (last_bit) sync_sh <= '0;
                end
            end
        end
    end

    always_comb begin
        count_next = fifo_count;
        if (push_ok && !pop) begin
            count_next = fifo_count + CW'(1);
        end else if (!push_ok && pop) begin
            count_next = fifo_count - CW'(1);
        end
    end

    assign rd_next = pop ? rd_ptr + AW'(1) : rd_ptr;

    // The registered head is precomputed. When the new head is the slot being
    // written this cycle, it comes from the payload rather than from memory.
    always_comb begin
        head_next = mem[rd_next];
        if (count_next == '0) begin
            head_next = '0;
        end else if (push_ok && (rd_next == wr_ptr)) begin
            head_next = payload_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= payload_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            pkt_valid  <= 1'b0;
            pkt_data   <= '0;
            pkt_rec    <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr     <= rd_next;
            fifo_count <= count_next;
            pkt_valid  <= (count_next != '0);
            pkt_data   <= head_next;
            pkt_rec    <= push_ok;
            // A new drop wins over a simultaneous clear.
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: doc/rf_pkt_receiver.md
Name: rf_pkt_receiver

Overview:
- Parametrised RF packet receiver: stretches short pulses on `din` into bit-period samples and hunts for a sync word.
- After a sync match, it assembles a PKT_W-bit payload and pushes it into a first-word-fall-through packet FIFO.
- It replaces the fixed 64-bit latch / shift buffer / packet register / counter chain.
- It feeds the future SPI readout block through a simple valid/read handshake.

Parameters:
- PKT_W, 64, payload width in bits (>= 2).
- DIV, 1000, clk cycles per bit period (>= 2); the default gives 1 ms at 1 MHz.
- SYNC_W, 8, sync word width (1..16).
- SYNC_WORD, 8'hA5, sync pattern, MSB received first.
- FIFO_DEPTH, 4, packet FIFO entries (power of two, >= 2).
- CW, derived as clog2(FIFO_DEPTH+1), width of fifo_count.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset, asynchronous, active-low.
- din, in, 1: RF detector output; pulses may be as short as 1 clk.
- pkt_rd, in, 1: pop the FIFO head.
- pkt_data, out, PKT_W: FIFO head payload, first bit received in the MSB.
- pkt_valid, out, 1: FIFO non-empty.
- pkt_rec, out, 1: one-cycle strobe when a packet is written into the FIFO.
- fifo_count, out, CW: number of stored packets.
- overflow, out, 1: sticky flag, a packet was dropped.
- ovf_clr, in, 1: clears overflow.
- hunting, out, 1: high in HUNT, low in RECV.

Behaviour:
- Reset (rst low, async):
  - div counter = 0, pulse flag = 0, sync shifter = 0, state = HUNT.
  - bit_cnt = 0, FIFO empty.
  - pkt_rec = 0, pkt_valid = 0, pkt_data = 0, fifo_count = 0, overflow = 0, hunting = 1.
- Bit timing:
  - div counter runs 0..DIV-1 and wraps.
  - tick = (div == DIV-1).
- Pulse stretch:
  - flag is set on any clk edge where din = 1.
  - bit sample at tick = flag | din.
  - On the tick edge, flag is loaded with 0; din is not re-sampled into it on that edge, so a pulse spanning the tick counts for both windows only if din is still high after the tick.
- HUNT:
  - On each tick the sync shifter takes {shifter[SYNC_W-2:0], bit}.
  - If that new value == SYNC_WORD: state goes to RECV, bit_cnt = 0, payload shifter cleared.
- RECV:
  - On each tick, payload = {payload[PKT_W-2:0], bit} and bit_cnt increments.
  - On the tick where bit_cnt == PKT_W-1, the completed payload (including this bit) is pushed on that same edge.
  - Also on that edge: state goes to HUNT, sync shifter cleared to 0. Payload bits never seed the next sync match.
- Push:
  - If the FIFO is not full, or a pop happens in the same cycle: the entry is written, and pkt_rec = 1 for exactly the following cycle.
  - Otherwise the packet is dropped, overflow is set, and pkt_rec stays 0.
- Pop:
  - pkt_rd with pkt_valid = 1 advances the head one cycle later.
  - pkt_rd while empty is ignored.
- FIFO and flag boundaries:
  - Push and pop in the same cycle: both succeed and fifo_count is unchanged. This applies at full too; at empty the pop is ignored and only the push lands.
  - pkt_data shows the head entry whenever pkt_valid = 1, and shows 0 when empty.
  - fifo_count saturates at FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
  - ovf_clr clears overflow. If ovf_clr coincides with a new drop, overflow stays 1.
- Reset mid-packet: a partially received payload is discarded with no pkt_rec.
- All outputs are registered.

Test Plan:
- Setup: PKT_W=16, DIV=4, SYNC_W=8, SYNC_WORD=8'hA5, FIFO_DEPTH=2.
  - Send bits A5 then 16'hBEEF, each '1' as a single-cycle din pulse mid-window.
  - Required: hunting falls after the 8th tick; pkt_rec pulses once, 1 cycle after the 24th tick; pkt_data = 16'hBEEF; fifo_count = 1.
- Idle line (din = 0) for 100 bit periods, then A4 + payload.
  - Required: no match, hunting stays 1, fifo_count = 0.
- Single-cycle din pulse on the cycle where div = DIV-1.
  - Required: that window samples 1, and the next window samples 0 if din is low afterwards.
- Three back-to-back packets 16'h0001, 16'h0002, 16'h0003 with no reads.
  - Required: fifo_count = 2, overflow = 1, pkt_data = 16'h0001.
  - Then pkt_rd for 2 cycles: 16'h0002 is shown, then pkt_valid = 0.
  - Then ovf_clr: overflow = 0.
- FIFO full with pkt_rd asserted on the push edge of a third packet.
  - Required: no overflow, fifo_count stays 2, head advances to the 2nd packet.
- Assert rst low asynchronously mid-payload (after 5 payload bits), then release and send a fresh A5 + 16'h1234.
  - Required: no pkt_rec before the fresh packet, then pkt_data = 16'h1234 and fifo_count = 1.
